// File: rtl/prog_loader_pkg.sv
// prog_loader shared package: loader state encoding and
// default instruction RAM geometry (DEPTH words of 32 bits).
package prog_loader_pkg;

    localparam int DEPTH_DEF  = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader bus bundle: serial byte stream in (byte_in/valid/ready)
// and RAM write port out (mem_RW/mem_address/mem_dataIN).
// master = loader side, slave = byte source / RAM side.
interface prog_loader_if #(
    parameter int ADDR_W = 5
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_RW;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_dataIN;

    modport master (
        input  byte_in, byte_valid,
        output byte_ready, mem_RW, mem_address, mem_dataIN
    );

    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, mem_RW, mem_address, mem_dataIN
    );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: counts transferred bytes and assembles them little-endian.
// Ports: clk, rst (async active-low), clr, take, byte_in -> last, word.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        take,
    input  logic [7:0]  byte_in,
    output logic        last,
    output logic [31:0] word
);
    logic [1:0] cnt;

    // Shifting in from the top leaves the first byte in [7:0]
    // once the fourth byte has arrived.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            word <= '0;
        end else if (clr) begin
            cnt  <= '0;
            word <= '0;
        end else if (take) begin
            cnt  <= cnt + 2'd1;
            word <= {byte_in, word[31:8]};
        end
    end

    assign last = take && (cnt == 2'd3);
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams bytes into 32-bit words, writes them to the
// instruction RAM, then verifies an XOR checksum byte.
// Ports: clk, rst (async active-low), start, word_count, bus (master),
// core_hold, busy, done, err.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    prog_loader_if.master     bus,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(DEPTH);

    state_t            state, state_n;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   total;
    logic [7:0]        csum;
    logic [31:0]       word;
    logic              load, take, data_take, last;

    assign load = start &&
                  (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign take      = bus.byte_valid && bus.byte_ready;
    assign data_take = take && (state == S_RECV);

    byte_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .clr     (load),
        .take    (data_take),
        .byte_in (bus.byte_in),
        .last    (last),
        .word    (word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    // idx is one bit wider than the address so it can reach DEPTH
    // after the final write without wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx   <= '0;
            total <= '0;
            csum  <= '0;
        end else if (load) begin
            idx   <= '0;
            total <= (word_count > DEPTH_N) ? DEPTH_N : word_count;
            csum  <= '0;
        end else begin
            if (data_take)         csum <= csum ^ bus.byte_in;
            if (state == S_WRITE)  idx  <= idx + (ADDR_W + 1)'(1);
        end
    end

    assign bus.mem_address = idx[ADDR_W-1:0];

    always_comb begin
        state_n        = state;
        bus.byte_ready = 1'b0;
        bus.mem_RW     = 1'b0;
        bus.mem_dataIN = '0;
        busy           = 1'b0;
        done           = 1'b0;
        err            = 1'b0;
        core_hold      = 1'b1;
        unique case (state)
            S_IDLE: begin
                if (start)
                    state_n = (word_count == '0) ? S_CSUM : S_RECV;
            end
            S_DONE: begin
                done      = 1'b1;
                core_hold = 1'b0;
                if (start)
                    state_n = (word_count == '0) ? S_CSUM : S_RECV;
            end
            S_ERROR: begin
                err = 1'b1;
                if (start)
                    state_n = (word_count == '0) ? S_CSUM : S_RECV;
            end
            S_RECV: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (last) state_n = S_WRITE;
            end
            S_WRITE: begin
                busy           = 1'b1;
                bus.mem_RW     = 1'b1;
                bus.mem_dataIN = word;
                state_n = (idx + (ADDR_W + 1)'(1) < total) ? S_RECV : S_CSUM;
            end
            S_CSUM: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (take)
                    state_n = (bus.byte_in == csum) ? S_DONE : S_ERROR;
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed and randomized loads checked against a
// queue-based model of the expected RAM writes and checksum outcome.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [5:0] word_count = '0;
    logic       core_hold, busy, done, err;

    int checks = 0;
    int errors = 0;

    logic [36:0] wq[$];

    prog_loader_if #(.ADDR_W(5)) bus ();

    prog_loader #(.DEPTH(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .bus        (bus),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_RW === 1'b1) begin
            wq.push_back({bus.mem_address, bus.mem_dataIN});
            check("ready_low_in_write", bus.byte_ready, 1'b0);
        end
    end

    function automatic logic [7:0] xsum(input logic [7:0] d[$]);
        logic [7:0] x = 8'h00;
        foreach (d[i]) x ^= d[i];
        return x;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.byte_valid = 1'b0;
        end
        @(negedge clk);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (bus.byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("byte_accept_timeout", 1'b0, 1'b1);
        else         @(posedge clk);
    endtask

    // mode 0: back-to-back, 1: one idle cycle per byte, 2: random gaps
    task automatic run_load(input string tag, input int count,
                            input logic [7:0] data[$],
                            input logic [7:0] cs, input int mode);
        int         nw;
        bit         ok;
        logic [31:0] ew;
        nw = (count > 32) ? 32 : count;
        ok = (cs == xsum(data));
        wq.delete();
        @(negedge clk);
        start      = 1'b1;
        word_count = 6'(count);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_start"}, busy, 1'b1);
        check({tag, "_hold_start"}, core_hold, 1'b1);
        foreach (data[i])
            send_byte(data[i], mode == 0 ? 0 :
                               mode == 1 ? 1 : int'($urandom_range(0, 3)));
        @(negedge clk);
        bus.byte_valid = 1'b0;
        @(negedge clk);
        check({tag, "_csum_ready"}, bus.byte_ready, 1'b1);
        check({tag, "_csum_busy"}, busy, 1'b1);
        check({tag, "_nwrites"}, wq.size(), nw);
        send_byte(cs, 0);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        check({tag, "_done"}, done, ok);
        check({tag, "_err"}, err, !ok);
        check({tag, "_hold"}, core_hold, !ok);
        check({tag, "_busy_end"}, busy, 1'b0);
        for (int i = 0; i < nw && i < wq.size(); i++) begin
            ew = {data[4*i+3], data[4*i+2], data[4*i+1], data[4*i]};
            check({tag, "_addr"}, wq[i][36:32], i);
            check({tag, "_data"}, wq[i][31:0], ew);
        end
        repeat (3) @(negedge clk);
        check({tag, "_done_hold"}, done, ok);
        check({tag, "_err_hold"}, err, !ok);
    endtask

    initial begin
        logic [7:0] q[$];
        int         c;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", bus.byte_ready, 1'b0);
        check("rst_rw", bus.mem_RW, 1'b0);
        check("rst_addr", bus.mem_address, 5'd0);
        check("rst_data", bus.mem_dataIN, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_hold", core_hold, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_rw", bus.mem_RW, 1'b0);

        q = '{8'h13, 8'h00, 8'h00, 8'h00};
        run_load("one_word", 1, q, 8'h13, 0);

        q = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
        run_load("two_words", 2, q, xsum(q), 0);

        q = '{8'h13, 8'h00, 8'h00, 8'h00};
        run_load("bad_csum", 1, q, 8'h00, 0);

        q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_load("toggle_valid", 1, q, xsum(q), 1);

        q = {};
        run_load("zero_words", 0, q, 8'h00, 0);

        wq.delete();
        @(negedge clk);
        start      = 1'b1;
        word_count = 6'd1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", bus.byte_ready, 1'b0);
        check("mid_rst_hold", core_hold, 1'b1);
        @(negedge clk);
        check("mid_rst_rw", bus.mem_RW, 1'b0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_rst_nowrite", wq.size(), 0);
        check("mid_rst_idle", busy, 1'b0);

        q = '{8'h44, 8'h33, 8'h22, 8'h11};
        run_load("after_rst", 1, q, xsum(q), 0);

        q = {};
        for (int i = 0; i < 128; i++) q.push_back(8'($urandom));
        run_load("clamp40", 40, q, xsum(q), 0);

        for (int t = 0; t < 6; t++) begin
            c = $urandom_range(1, 5);
            q = {};
            for (int i = 0; i < 4 * c; i++) q.push_back(8'($urandom));
            run_load("rand", c, q,
                     ($urandom_range(0, 1) != 0) ? xsum(q) : ~xsum(q), 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning the number of 32-bit words in the instruction RAM.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning the instruction RAM address width; DEPTH equals 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  meaning the asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  meaning a one-cycle load request, sampled only in IDLE, DONE or ERROR.
REQ-006 SHALL have port word_count  input  ADDR_W+1  meaning the number of words to load, sampled on start; 0 means no words.
REQ-007 SHALL have port byte_in  input  8  meaning a serial program byte.
REQ-008 SHALL have port byte_valid  input  1  meaning byte_in holds a valid byte.
REQ-009 SHALL have port byte_ready  output  1  meaning the loader accepts byte_in this cycle.
REQ-010 SHALL have port mem_RW  output  1  meaning the RAM write strobe (1 = write).
REQ-011 SHALL have port mem_address  output  ADDR_W  meaning the RAM word address.
REQ-012 SHALL have port mem_dataIN  output  32  meaning the RAM write data.
REQ-013 SHALL have port core_hold  output  1  meaning the core must be held in reset (1 = hold).
REQ-014 SHALL have port busy  output  1  meaning a load is in progress.
REQ-015 SHALL have port done  output  1  meaning the last load finished with a checksum match.
REQ-016 SHALL have port err  output  1  meaning the last load finished with a checksum mismatch.

Function
REQ-017 SHALL implement the states IDLE, RECV, WRITE, CSUM, DONE and ERROR.
REQ-018 SHALL move IDLE/DONE/ERROR->RECV on start with word_count>0, and ->CSUM on start with word_count=0.
REQ-019 SHALL treat a byte as transferred only in a cycle where byte_valid=1 and byte_ready=1.
REQ-020 SHALL assert byte_ready only in RECV and CSUM.
REQ-021 SHALL assemble each word little-endian in RECV: the first byte goes to [7:0] and the fourth to [31:24].
REQ-022 SHALL go RECV->WRITE in the cycle after the fourth byte transfers.
REQ-023 SHALL make WRITE last exactly one cycle, with mem_RW=1, mem_address=word index, and mem_dataIN=assembled word.
REQ-024 SHALL keep mem_RW=0 in every state except WRITE.
REQ-025 SHALL go WRITE->RECV while words written < word_count, and WRITE->CSUM after the last word.
REQ-026 SHALL start the word index at 0, increment it after each WRITE, and never wrap it within one load.
REQ-027 SHALL clamp a word_count above DEPTH to DEPTH.
REQ-028 SHALL keep a running 8-bit XOR of all data bytes, cleared on start.
REQ-029 SHALL, in CSUM, accept one byte and go to DONE when it equals the running XOR, otherwise to ERROR.
REQ-030 SHALL hold DONE and ERROR until the next start; done=1 only in DONE, err=1 only in ERROR.
REQ-031 SHALL drive busy=1 in RECV, WRITE and CSUM.
REQ-032 SHALL drive core_hold=1 in every state except DONE.
REQ-033 SHALL ignore start while busy=1.
REQ-034 SHALL keep the partial word and stall indefinitely while byte_valid=0; there is no timeout.

Reset
REQ-035 SHALL, on rst low, asynchronously enter IDLE.
REQ-036 SHALL, on rst low, clear the word index, byte counter, partial word and XOR.
REQ-037 SHALL, on rst low, drive mem_RW=0, byte_ready=0, busy=0, done=0, err=0, core_hold=1, mem_address=0 and mem_dataIN=0.
REQ-038 SHALL, on reset during a load, discard the partial word; words already written remain in RAM.
REQ-039 SHALL never produce a WRITE pulse in the cycle reset is released.

Structure
REQ-040 SHALL place the state encoding and the DEPTH/ADDR_W defaults in the shared processor package.
REQ-041 SHALL use one sub-module, byte_packer (byte counter plus little-endian shift assembly), instantiated once.

Verification
REQ-042 SHALL test: start, word_count=1, bytes 13,00,00,00, checksum 13 -> one WRITE at address 0 with data 0x00000013; then DONE, done=1, core_hold=0.
REQ-043 SHALL test: word_count=2, words 0x00500093/0x00100113 streamed, correct XOR -> writes at addresses 0 and 1; done=1.
REQ-044 SHALL test: word_count=1, bytes 13,00,00,00, checksum 00 -> ERROR, err=1, core_hold=1.
REQ-045 SHALL test: byte_valid toggled every other cycle for a full word -> same word written; byte_ready=0 during WRITE.
REQ-046 SHALL test: rst low after 2 bytes of word 0 -> IDLE next cycle, mem_RW stays 0, no write at address 0.
REQ-047 SHALL test: word_count=40 -> exactly 32 writes (addresses 0..31), no wrap, then CSUM.
